// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a synchronized and
// debounced lock, retries on timeout, and raises READY only while lock holds.
module pll_rst_seq #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       LOCKED,
  input  logic       PWRDWN_REQ,
  input  logic       RESTART,
  output logic       PLL_RST,
  output logic       PLL_PWRDWN,
  output logic       READY,
  output logic       FAIL,
  output logic       LOCK_LOST,
  output logic [7:0] RETRY_CNT
);

  localparam int unsigned MAX_SPAN_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_SPAN   = (MAX_SPAN_A > STABLE_CYCLES) ? MAX_SPAN_A : STABLE_CYCLES;

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
    $error("pll_rst_seq: RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES must be >= 1");
  end
  if (MAX_RETRIES > 255) begin : g_bad_retries
    $error("pll_rst_seq: MAX_RETRIES must not exceed 255");
  end
  if (CNT_WIDTH < 32) begin : g_cnt_chk
    if (longint'(MAX_SPAN) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_cnt_small
      $error("pll_rst_seq: CNT_WIDTH too small for the configured cycle counts");
    end
  end

  localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [7:0]           RETRY_LIMIT = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL,
    ST_PWRDN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           retry_q, retry_d;
  logic                 lk_meta_q, lk_q;
  logic                 cnt_clr, lock_lost_d;
  logic                 pll_rst_q, pwrdwn_q, ready_q, fail_q, lock_lost_q;

  always_comb begin
    // NOTE: every signal gets a default up front so no path can infer a latch.
    state_d     = state_q;
    retry_d     = retry_q;
    cnt_clr     = 1'b0;
    lock_lost_d = 1'b0;

    if (PWRDWN_REQ) begin
      state_d = ST_PWRDN;
    end else if (state_q == ST_PWRDN) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else if (RESTART) begin
      // A restart while already in RESET must still rewind the reset count.
      state_d = ST_RESET;
      retry_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET;
              retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            end
          end
        end
        ST_STABLE: begin
          if (!lk_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lk_q) begin
            state_d     = ST_RESET;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAIL, ST_PWRDN: ;
        default: state_d = ST_RESET;
      endcase
    end

    if (cnt_clr || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      lk_meta_q   <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      pwrdwn_q    <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      lk_meta_q   <= LOCKED;
      lk_q        <= lk_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= state_d inside {ST_RESET, ST_FAIL, ST_PWRDN};
      pwrdwn_q    <= (state_d == ST_PWRDN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
      lock_lost_q <= lock_lost_d;
    end
  end

  assign PLL_RST    = pll_rst_q;
  assign PLL_PWRDWN = pwrdwn_q;
  assign READY      = ready_q;
  assign FAIL       = fail_q;
  assign LOCK_LOST  = lock_lost_q;
  assign RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: an elapsed-edge reference model checked every cycle,
// plus directed scenarios with hand-computed timing checks.
module tb_pll_rst_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 5;
  localparam int MAX_RETRIES   = 2;

  logic       CLK = 1'b0;
  logic       RSTN, LOCKED, PWRDWN_REQ, RESTART;
  logic       PLL_RST, PLL_PWRDWN, READY, FAIL, LOCK_LOST;
  logic [7:0] RETRY_CNT;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pll_rst_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_WIDTH    (16)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .LOCKED    (LOCKED),
    .PWRDWN_REQ(PWRDWN_REQ),
    .RESTART   (RESTART),
    .PLL_RST   (PLL_RST),
    .PLL_PWRDWN(PLL_PWRDWN),
    .READY     (READY),
    .FAIL      (FAIL),
    .LOCK_LOST (LOCK_LOST),
    .RETRY_CNT (RETRY_CNT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus the number of edges spent in it; LOCKED history
  // gives the value the sequencer sees two edges after sampling.
  typedef enum int {P_RESET, P_WAIT, P_STABLE, P_RUN, P_FAIL, P_PWRDN} phase_e;
  phase_e m_phase;
  int     m_elapsed;
  int     m_retry;
  bit     m_lost;
  bit     lk_hist[$];

  task automatic model_reset();
    m_phase   = P_RESET;
    m_elapsed = 0;
    m_retry   = 0;
    m_lost    = 1'b0;
    lk_hist   = '{1'b0, 1'b0};
  endtask

  task automatic model_edge();
    int     edge_no;
    bit     lk;
    bit     rewind;
    phase_e nxt;
    edge_no = m_elapsed + 1;
    lk      = lk_hist[0];
    lk_hist.push_back(LOCKED);
    void'(lk_hist.pop_front());
    nxt    = m_phase;
    rewind = 1'b0;
    m_lost = 1'b0;
    if (PWRDWN_REQ) begin
      nxt = P_PWRDN;
    end else if (m_phase == P_PWRDN) begin
      nxt     = P_RESET;
      m_retry = 0;
    end else if (RESTART) begin
      nxt     = P_RESET;
      m_retry = 0;
      rewind  = 1'b1;
    end else if (m_phase == P_RESET && edge_no == RST_CYCLES) begin
      nxt = P_WAIT;
    end else if (m_phase == P_WAIT && lk) begin
      nxt = P_STABLE;
    end else if (m_phase == P_WAIT && edge_no == LOCK_TIMEOUT) begin
      if (m_retry >= MAX_RETRIES) nxt = P_FAIL;
      else begin
        nxt     = P_RESET;
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end else if (m_phase == P_STABLE && !lk) begin
      nxt = P_WAIT;
    end else if (m_phase == P_STABLE && edge_no == STABLE_CYCLES) begin
      nxt     = P_RUN;
      m_retry = 0;
    end else if (m_phase == P_RUN && !lk) begin
      nxt    = P_RESET;
      m_lost = 1'b1;
    end
    m_elapsed = (rewind || nxt != m_phase) ? 0 : edge_no;
    m_phase   = nxt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTN);
      if (RSTN !== 1'b1) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      check("cyc_pll_rst", PLL_RST, m_phase inside {P_RESET, P_FAIL, P_PWRDN});
      check("cyc_pwrdwn", PLL_PWRDWN, m_phase == P_PWRDN);
      check("cyc_ready", READY, m_phase == P_RUN);
      check("cyc_fail", FAIL, m_phase == P_FAIL);
      check("cyc_lock_lost", LOCK_LOST, m_lost);
      check("cyc_retry", RETRY_CNT, m_retry);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Counts consecutive negedges (starting now) on which PLL_RST holds lvl.
  task automatic count_level(input logic lvl, input int expected, input string name);
    int n;
    n = 0;
    while (PLL_RST === lvl && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check(name, n, expected);
  endtask

  // From WAIT_LOCK with a low synchronizer: READY follows 8 edges after LOCKED rises.
  task automatic relock(input string name);
    LOCKED = 1'b1;
    tick(7);
    check({name, "_ready_early"}, READY, 0);
    tick(1);
    check({name, "_ready"}, READY, 1);
    check({name, "_retry"}, RETRY_CNT, 0);
    check({name, "_fail"}, FAIL, 0);
  endtask

  task automatic restart_pulse();
    RESTART = 1'b1;
    tick(1);
    RESTART = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; LOCKED = 1'b0; PWRDWN_REQ = 1'b0; RESTART = 1'b0;
    tick(2);
    check("rst_pll_rst", PLL_RST, 1);
    check("rst_ready", READY, 0);
    check("rst_pwrdwn", PLL_PWRDWN, 0);
    check("rst_fail", FAIL, 0);
    check("rst_retry", RETRY_CNT, 0);

    // Normal lock: LOCKED rises 10 cycles after PLL_RST falls.
    RSTN = 1'b1;
    count_level(1'b1, RST_CYCLES, "normal_rst_len");
    tick(10);
    relock("normal");

    // Lock loss in RUN.
    LOCKED = 1'b0;
    tick(2);
    check("loss_ready_held", READY, 1);
    tick(1);
    check("loss_ready_drop", READY, 0);
    check("loss_pulse", LOCK_LOST, 1);
    check("loss_retry", RETRY_CNT, 0);
    tick(1);
    check("loss_pulse_end", LOCK_LOST, 0);
    count_level(1'b1, RST_CYCLES - 1, "loss_rst_len");
    tick(2);
    relock("after_loss");

    // Timeouts and retries up to FAIL, then RESTART.
    LOCKED = 1'b0;
    restart_pulse();
    check("restart_no_loss", LOCK_LOST, 0);
    count_level(1'b1, RST_CYCLES, "restart_rst_len");
    for (int a = 1; a <= MAX_RETRIES + 1; a++) begin
      count_level(1'b0, LOCK_TIMEOUT, "timeout_wait_len");
      if (a <= MAX_RETRIES) begin
        check("retry_step", RETRY_CNT, a);
        count_level(1'b1, RST_CYCLES, "retry_rst_len");
      end else begin
        check("fail_set", FAIL, 1);
        check("fail_pll_rst", PLL_RST, 1);
        check("fail_retry", RETRY_CNT, MAX_RETRIES);
      end
    end
    tick(10);
    check("fail_sticky", FAIL, 1);
    check("fail_rst_held", PLL_RST, 1);
    restart_pulse();
    check("fail_cleared", FAIL, 0);
    check("fail_retry_cleared", RETRY_CNT, 0);
    count_level(1'b1, RST_CYCLES, "fail_restart_rst_len");

    // Debounce with one prior timeout: high 3, low 2, then high.
    count_level(1'b0, LOCK_TIMEOUT, "deb_wait_len");
    check("deb_retry", RETRY_CNT, 1);
    count_level(1'b1, RST_CYCLES, "deb_rst_len");
    LOCKED = 1'b1; tick(3);
    LOCKED = 1'b0; tick(2);
    LOCKED = 1'b1; tick(7);
    check("deb_ready_early", READY, 0);
    check("deb_retry_held", RETRY_CNT, 1);
    tick(1);
    check("deb_ready", READY, 1);
    check("deb_retry_clear", RETRY_CNT, 0);

    // Power-down beats a simultaneous RESTART mid-WAIT_LOCK.
    LOCKED = 1'b0;
    restart_pulse();
    count_level(1'b1, RST_CYCLES, "pd_rst_len");
    count_level(1'b0, LOCK_TIMEOUT, "pd_wait_len");
    count_level(1'b1, RST_CYCLES, "pd_rst2_len");
    tick(5);
    PWRDWN_REQ = 1'b1;
    RESTART    = 1'b1;
    tick(1);
    RESTART = 1'b0;
    check("pd_pwrdwn", PLL_PWRDWN, 1);
    check("pd_pll_rst", PLL_RST, 1);
    check("pd_ready", READY, 0);
    tick(6);
    check("pd_hold", PLL_PWRDWN, 1);
    PWRDWN_REQ = 1'b0;
    tick(1);
    check("pd_release", PLL_PWRDWN, 0);
    check("pd_release_retry", RETRY_CNT, 0);
    count_level(1'b1, RST_CYCLES, "pd_release_rst_len");
    tick(3);
    relock("after_pd");

    // Asynchronous reset between edges while in RUN.
    #2;
    RSTN = 1'b0;
    #1;
    check("async_ready", READY, 0);
    check("async_pll_rst", PLL_RST, 1);
    check("async_retry", RETRY_CNT, 0);
    @(negedge CLK);
    tick(1);
    RSTN = 1'b1;
    count_level(1'b1, RST_CYCLES, "async_rst_len");
    tick(5);
    check("async_relock_early", READY, 0);
    tick(1);
    check("async_relock", READY, 1);

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: sequence still running at %0t, expected done", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
